instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 The module SHALL expose parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 stallF  input  1  hazard-unit hold; 1 = decode does not consume head entry this cycle.
REQ-006 redirect  input  1  taken branch or jump resolved in decode.
REQ-007 redirectPc  input  32  target address when redirect=1.
REQ-008 memReq  output  1  instruction-memory request valid.
REQ-009 memAddr  output  32  word-aligned fetch address, stable while memReq=1.
REQ-010 memAck  input  1  memory response valid; ignored unless memReq=1.
REQ-011 memRdata  input  32  instruction word, valid with memAck.
REQ-012 validF  output  1  head entry present.
REQ-013 instrF  output  32  head instruction; 32'h00000000 (NOP) when validF=0.
REQ-014 pcPlus4F  output  32  head entry fetch address + 4; 0 when validF=0.

Function
REQ-015 Request FSM SHALL have states IDLE, WAIT, DROP; memReq=1 exactly in WAIT and DROP.
REQ-016 IDLE->WAIT when no redirect and space available; capture reqPc<=pc, pc<=pc+4.
REQ-017 Space available SHALL mean queue occupancy after this cycle's push/pop is below DEPTH.
REQ-018 WAIT with memAck: push {memRdata, reqPc+4}; if space, issue next (stay WAIT, memAddr=new reqPc next cycle), else IDLE.
REQ-019 WAIT with redirect, no memAck: go DROP; same cycle memAck and redirect: response discarded, go IDLE.
REQ-020 DROP with memAck: discard data, go IDLE; redirect in DROP stays DROP.
REQ-021 Redirect SHALL empty the queue next cycle, set pc<=redirectPc with bits[1:0] forced 0, and have priority over stallF and pops.
REQ-022 Pop SHALL occur when validF=1, stallF=0, redirect=0; push and pop in same cycle leave occupancy unchanged.
REQ-023 Queue SHALL never overflow; no push occurs on a full queue; pop on empty is a no-op.
REQ-024 Address arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-025 Sustained throughput SHALL be one instruction per cycle when memAck returns every cycle and stallF=0.
REQ-026 Minimum latency memAck-to-validF SHALL be one cycle (macro absent).

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, queue empty, pc=RESET_PC, memReq=0, validF=0, instrF=0, pcPlus4F=0, memAddr=0.
REQ-028 Reset mid-request SHALL abandon the outstanding request; any memAck after rst release while in IDLE is ignored.
REQ-029 First request SHALL issue in the first clock edge after rst deasserts, to RESET_PC.

Configuration
REQ-030 Macro IFU_BYPASS_EN defined: when queue empty, state WAIT, memAck=1, redirect=0, memRdata/reqPc+4 SHALL drive instrF/pcPlus4F with validF=1 in the same cycle, and if stallF=0 the entry is consumed without being written.
REQ-031 Macro IFU_BYPASS_EN undefined: outputs SHALL come only from queue registers, zero combinational path from memAck/memRdata to outputs.

Verification
REQ-032 Reset release, memAck held 1, stallF=0 -> memAddr 0,4,8,12 on consecutive cycles; instrF follows one cycle behind; pcPlus4F 4,8,12.
REQ-033 stallF=1 for 8 cycles, DEPTH=4 -> exactly 4 pushes, memReq drops to 0, head instrF stable; release -> 4 pops in order, fetching resumes at 16.
REQ-034 Redirect to 32'h00000103 while in WAIT, memAck next cycle -> that response discarded, queue empty, next memAddr 32'h00000100.
REQ-035 Redirect and memAck same cycle -> no push, state IDLE, next request to redirect target.
REQ-036 pc=32'hFFFFFFFC fetched -> pcPlus4F=0, next memAddr=0.
REQ-037 rst pulsed low while WAIT with 2 entries queued -> validF=0 and memReq=0 immediately; late memAck ignored; refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response bus
//   memReq   request valid (master -> slave)
//   memAddr  word-aligned fetch address, stable while memReq=1
//   memAck   response valid, meaningful only while memReq=1 (slave -> master)
//   memRdata instruction word, valid with memAck
interface instr_fetch_unit_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;
  modport master(output memReq, memAddr, input memAck, memRdata);
  modport slave(input memReq, memAddr, output memAck, memRdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry prefetch queue
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   stallF      1 = decode holds the head entry this cycle
//   redirect    taken branch/jump; flushes queue and reloads pc from redirectPc
//   redirectPc  redirect target (bits [1:0] ignored)
//   mem         instruction-memory bus (master side)
//   validF      head entry present
//   instrF      head instruction, 0 when validF=0
//   pcPlus4F    head fetch address + 4, 0 when validF=0
// Optional macro IFU_BYPASS_EN: forward a response straight to the outputs when the queue is empty.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic               redirect,
  input  logic [31:0]        redirectPc,
  instr_fetch_unit_if.master mem,
  output logic               validF,
  output logic [31:0]        instrF,
  output logic [31:0]        pcPlus4F
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, stateNext;
  logic [31:0] pc, pcNext, reqPc;
  logic [31:0] instrQ [DEPTH];
  logic [31:0] pcp4Q [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count, occNext;
  logic ack, push, pop, space, qValid, issue, byp;
  assign qValid = count != '0;
  assign ack = mem.memReq & mem.memAck;
  assign mem.memReq = state != IDLE;
  assign mem.memAddr = mem.memReq ? reqPc : '0;
`ifdef IFU_BYPASS_EN
  assign byp = !qValid && state == WAIT && mem.memAck && !redirect;
  assign validF = qValid | byp;
  assign instrF = qValid ? instrQ[rdPtr] : byp ? mem.memRdata : '0;
  assign pcPlus4F = qValid ? pcp4Q[rdPtr] : byp ? reqPc + 32'd4 : '0;
`else
  assign byp = 1'b0;
  assign validF = qValid;
  assign instrF = qValid ? instrQ[rdPtr] : '0;
  assign pcPlus4F = qValid ? pcp4Q[rdPtr] : '0;
`endif
  assign pop = qValid & ~stallF & ~redirect;
  // a bypassed response consumed this cycle never occupies a slot; count[AW] set means full
  assign push = state == WAIT && mem.memAck && !redirect && !(byp && !stallF) && (!count[AW] || pop);
  assign occNext = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign space = occNext < CW'(DEPTH);
  always_comb begin
    stateNext = state;
    issue = 1'b0;
    unique case (state)
      IDLE: begin
        issue = !redirect && space;
        stateNext = issue ? WAIT : IDLE;
      end
      WAIT:
        if (redirect) stateNext = ack ? IDLE : DROP;
        else if (ack) begin
          issue = space;
          stateNext = space ? WAIT : IDLE;
        end
      DROP: stateNext = ack ? IDLE : DROP;
      default: stateNext = IDLE;
    endcase
    pcNext = redirect ? {redirectPc[31:2], 2'b00} : issue ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      reqPc <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      if (issue) reqPc <= pc;
      count <= occNext;
      rdPtr <= redirect ? '0 : rdPtr + AW'(pop);
      wrPtr <= redirect ? '0 : wrPtr + AW'(push);
    end
  always_ff @(posedge clk)
    if (push) begin
      instrQ[wrPtr] <= mem.memRdata;
      pcp4Q[wrPtr] <= reqPc + 32'd4;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stallF = 1'b0, redirect = 1'b0, ackIn = 1'b0;
  logic [31:0] redirectPc = '0;
  logic validF;
  logic [31:0] instrF, pcPlus4F;
  int tests = 0, fails = 0;
  instr_fetch_unit_if mem();
  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirectPc(redirectPc),
    .mem(mem), .validF(validF), .instrF(instrF), .pcPlus4F(pcPlus4F));
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h13579BDF;
  endfunction
  assign mem.memAck = ackIn;
  assign mem.memRdata = word(mem.memAddr);
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // Model: one outstanding request at a time, a FIFO of fetched words
  typedef struct {logic [31:0] ins; logic [31:0] p4;} ent_t;
  ent_t mq[$];
  bit outst = 0, drop = 0, got, resp, canIssue;
  logic [31:0] mPc = 32'h0, mAddr = 32'h0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      mq.delete();
      outst = 0;
      drop = 0;
      mPc = 32'h0;
      mAddr = 32'h0;
    end else begin
      resp = outst && ackIn;
      got = resp && !drop && !redirect;
      canIssue = !outst || got;
      if (mq.size() > 0 && !stallF && !redirect) void'(mq.pop_front());
      if (got) mq.push_back('{word(mAddr), mAddr + 32'd4});
      if (redirect) begin
        mq.delete();
        mPc = {redirectPc[31:2], 2'b00};
      end
      if (resp) begin
        outst = 0;
        drop = 0;
      end else if (outst && redirect) drop = 1;
      if (canIssue && !redirect && mq.size() < DEPTH) begin
        mAddr = mPc;
        mPc = mPc + 32'd4;
        outst = 1;
      end
    end
  always @(negedge clk) begin
    chk("memReq", {31'b0, mem.memReq}, {31'b0, outst});
    chk("memAddr", mem.memAddr, outst ? mAddr : 32'h0);
    chk("validF", {31'b0, validF}, {31'b0, mq.size() > 0});
    chk("instrF", instrF, mq.size() > 0 ? mq[0].ins : 32'h0);
    chk("pcPlus4F", pcPlus4F, mq.size() > 0 ? mq[0].p4 : 32'h0);
  end
  task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic a);
    stallF = s;
    redirect = r;
    redirectPc = rp;
    ackIn = a;
    @(posedge clk);
    #2;
  endtask
  task automatic pulseReset();
    rst = 1'b0;
    #1;
    chk("rst memReq", {31'b0, mem.memReq}, 32'h0);
    chk("rst validF", {31'b0, validF}, 32'h0);
    chk("rst memAddr", mem.memAddr, 32'h0);
    chk("rst instrF", instrF, 32'h0);
    chk("rst pcPlus4F", pcPlus4F, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset memReq", {31'b0, mem.memReq}, 32'h0);
    chk("reset validF", {31'b0, validF}, 32'h0);
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    chk("first addr", mem.memAddr, 32'h0);
    chk("first validF", {31'b0, validF}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("addr4", mem.memAddr, 32'h4);
    chk("p4 4", pcPlus4F, 32'h4);
    chk("instr0", instrF, word(32'h0));
    cyc(0, 0, 0, 1);
    chk("addr8", mem.memAddr, 32'h8);
    chk("p4 8", pcPlus4F, 32'h8);
    cyc(0, 0, 0, 1);
    chk("addr12", mem.memAddr, 32'hC);
    chk("p4 12", pcPlus4F, 32'hC);
    pulseReset();
    repeat (8) cyc(1, 0, 0, 1);
    chk("stall memReq", {31'b0, mem.memReq}, 32'h0);
    chk("stall entries", mq.size(), DEPTH);
    chk("stall head", instrF, word(32'h0));
    chk("stall p4", pcPlus4F, 32'h4);
    cyc(0, 0, 0, 1);
    chk("resume addr", mem.memAddr, 32'h10);
    chk("pop1", pcPlus4F, 32'h8);
    cyc(0, 0, 0, 1);
    chk("pop2", pcPlus4F, 32'hC);
    cyc(0, 0, 0, 1);
    chk("pop3", pcPlus4F, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h103, 0);
    chk("drop validF", {31'b0, validF}, 32'h0);
    chk("drop memReq", {31'b0, mem.memReq}, 32'h1);
    cyc(0, 0, 0, 1);
    chk("drop done", {31'b0, mem.memReq}, 32'h0);
    chk("drop discarded", {31'b0, validF}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("redir addr", mem.memAddr, 32'h100);
    cyc(1, 0, 0, 1);
    chk("pre same validF", {31'b0, validF}, 32'h1);
    cyc(1, 1, 32'h200, 1);
    chk("same memReq", {31'b0, mem.memReq}, 32'h0);
    chk("same validF", {31'b0, validF}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("same addr", mem.memAddr, 32'h200);
    cyc(0, 1, 32'hFFFFFFFC, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("wrap addr", mem.memAddr, 32'hFFFFFFFC);
    cyc(1, 0, 0, 1);
    chk("wrap p4", pcPlus4F, 32'h0);
    chk("wrap validF", {31'b0, validF}, 32'h1);
    chk("wrap next", mem.memAddr, 32'h0);
    cyc(1, 0, 0, 1);
    chk("two queued", mq.size(), 2);
    pulseReset();
    chk("late ack ignored", {31'b0, validF}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("refetch addr", mem.memAddr, 32'h0);
    chk("refetch validF", {31'b0, validF}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("refetch p4", pcPlus4F, 32'h4);
    for (int i = 0; i < 300; i++)
      cyc(i % 5 == 0 || i % 7 == 3, i % 17 == 9, i * 64 + 3, i % 3 != 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
